spi2fifo_mc: RTL and testbench

//  Multi-chip, parametrised successor to the two-chip ADC SPI-to-FIFO packer, in the fifo_txc domain.

---
 rtl/spi2fifo_mc.sv | 156 +++++++++++++++
 tb/tb_spi2fifo_mc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/spi2fifo_mc.sv
// -----------------------------------------------------------------------------
// spi2fifo_mc
// Multi-chip ADC sample packer. On a frame strobe it snapshots one sample word
// per chip and writes it MSB-byte-first to FIFO_NUM parallel FIFOs. Each beat
// carries one byte lane per chip, with chip 0 in the top lane. A header beat
// can optionally be prepended to each frame. Frames that arrive while any FIFO
// is full are dropped, and the drops are counted.
//
// Ports
//   fifo_txc   in   clock
//   rst_n      in   asynchronous reset, active-low
//   fs         in   frame start (level), held high until fd is seen
//   fd         out  frame done (high while in DONE)
//   hdr_en     in   prepend header beat {8'hA5, frame_cnt}
//   chip_rxd   in   chip c sample at [c*8*SAMPLE_BYTES +: 8*SAMPLE_BYTES]
//   fifo_full  in   per-FIFO full flag
//   fifo_txen  out  per-FIFO write enable (all bits identical)
//   fifo_txd   out  write data, one byte lane per chip
//   frame_cnt  out  frames written (wraps)
//   drop_cnt   out  frames dropped (saturates)
// -----------------------------------------------------------------------------
module spi2fifo_mc #(
    parameter int CHIP_NUM     = 2,
    parameter int SAMPLE_BYTES = 2,
    parameter int FIFO_NUM     = 2,
    parameter int CNT_W        = 8
) (
    input  logic                             fifo_txc,
    input  logic                             rst_n,
    input  logic                             fs,
    output logic                             fd,
    input  logic                             hdr_en,
    input  logic [CHIP_NUM*8*SAMPLE_BYTES-1:0] chip_rxd,
    input  logic [FIFO_NUM-1:0]              fifo_full,
    output logic [FIFO_NUM-1:0]              fifo_txen,
    output logic [8*CHIP_NUM-1:0]            fifo_txd,
    output logic [CNT_W-1:0]                 frame_cnt,
    output logic [CNT_W-1:0]                 drop_cnt
);

    localparam int SW    = 8 * SAMPLE_BYTES;      // bits per chip sample
    localparam int DW    = 8 * CHIP_NUM;          // bits per beat
    localparam int HW    = 8 * (CHIP_NUM - 1);    // header count field width
    localparam int IDX_W = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(SAMPLE_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        WORK = 3'd2,
        HEAD = 3'd3,
        DATA = 3'd4,
        DONE = 3'd5,
        DROP = 3'd6
    } state_t;

    state_t                   state_reg;
    logic [CHIP_NUM*SW-1:0]   snap_reg;
    logic [IDX_W-1:0]         idx_reg;        // byte index of the beat currently on fifo_txd
    logic [DW-1:0]            txd_reg;
    logic [CNT_W-1:0]         frame_cnt_reg;
    logic [CNT_W-1:0]         drop_cnt_reg;

    // Data for the beat that will be presented after the next edge. From WORK
    // the snapshot is being loaded on that same edge, so read chip_rxd
    // directly; otherwise read the held snapshot.
    logic [CHIP_NUM*SW-1:0]   beat_src;
    logic [IDX_W-1:0]         beat_idx;
    logic [DW-1:0]            beat_data;
    logic [HW-1:0]            hdr_cnt;
    logic [DW-1:0]            hdr_data;

    always_comb begin
        beat_src = (state_reg == WORK) ? chip_rxd : snap_reg;
        beat_idx = (state_reg == DATA) ? (idx_reg - IDX_W'(1)) : IDX_TOP;
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHIP_NUM; gi++) begin : g_lane
            assign beat_data[8*(CHIP_NUM-gi)-1 -: 8] = beat_src[gi*SW + 8*int'(beat_idx) +: 8];
        end
    endgenerate

    // Header count field: truncate or zero-extend frame_cnt to HW bits.
    generate
        if (CNT_W >= HW) begin : g_hdr_trunc
            assign hdr_cnt = frame_cnt_reg[HW-1:0];
        end else begin : g_hdr_ext
            assign hdr_cnt = {{(HW-CNT_W){1'b0}}, frame_cnt_reg};
        end
    endgenerate

    assign hdr_data = {8'hA5, hdr_cnt};

    always_ff @(posedge fifo_txc or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            snap_reg      <= '0;
            idx_reg       <= '0;
            txd_reg       <= '0;
            frame_cnt_reg <= '0;
            drop_cnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: state_reg <= WAIT;
                WAIT: begin
                    if (!(|fifo_full)) begin
                        state_reg <= WORK;
                    end else if (fs) begin
                        state_reg <= DROP;
                        if (drop_cnt_reg != '1) begin
                            drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                WORK: begin
                    if (fs) begin
                        snap_reg <= chip_rxd;
                        idx_reg  <= IDX_TOP;
                        if (hdr_en) begin
                            state_reg <= HEAD;
                            txd_reg   <= hdr_data;
                        end else begin
                            state_reg <= DATA;
                            txd_reg   <= beat_data;
                        end
                    end
                end
                HEAD: begin
                    state_reg <= DATA;
                    txd_reg   <= beat_data;
                end
                DATA: begin
                    if (idx_reg == '0) begin
                        state_reg     <= DONE;
                        frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
                    end else begin
                        idx_reg <= idx_reg - IDX_W'(1);
                        txd_reg <= beat_data;
                    end
                end
                DONE: if (!fs) state_reg <= WAIT;
                DROP: if (!fs) state_reg <= WAIT;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign fd        = (state_reg == DONE);
    assign fifo_txen = {FIFO_NUM{(state_reg == HEAD) || (state_reg == DATA)}};
    assign fifo_txd  = txd_reg;
    assign frame_cnt = frame_cnt_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_spi2fifo_mc.sv
// -----------------------------------------------------------------------------
// tb_spi2fifo_mc
// Directed bench for spi2fifo_mc: a default 2-chip/2-byte instance and a
// 4-chip/3-byte instance. Inputs are driven and outputs sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_spi2fifo_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // default instance
    logic        fs, hdr_en, fd;
    logic [31:0] rxd;
    logic [1:0]  full, txen;
    logic [15:0] txd;
    logic [7:0]  fcnt, dcnt;
    // 4-chip, 3-byte instance
    logic        fs2, hdr2, fd2;
    logic [95:0] rxd2;
    logic [1:0]  full2, txen2;
    logic [31:0] txd2;
    logic [7:0]  fcnt2, dcnt2;

    spi2fifo_mc #(.CHIP_NUM(2), .SAMPLE_BYTES(2), .FIFO_NUM(2), .CNT_W(8)) dut (
        .fifo_txc(clk), .rst_n(rst_n), .fs(fs), .fd(fd), .hdr_en(hdr_en),
        .chip_rxd(rxd), .fifo_full(full), .fifo_txen(txen), .fifo_txd(txd),
        .frame_cnt(fcnt), .drop_cnt(dcnt)
    );

    spi2fifo_mc #(.CHIP_NUM(4), .SAMPLE_BYTES(3), .FIFO_NUM(2), .CNT_W(8)) dut2 (
        .fifo_txc(clk), .rst_n(rst_n), .fs(fs2), .fd(fd2), .hdr_en(hdr2),
        .chip_rxd(rxd2), .fifo_full(full2), .fifo_txen(txen2), .fifo_txd(txd2),
        .frame_cnt(fcnt2), .drop_cnt(dcnt2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one frame on the default instance and checks beats, enables,
    // fd timing and fd release. mutate changes chip_rxd right after capture.
    task automatic run1(input string tag, input logic h, input logic mutate,
                        input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                        input int exp_nb);
        logic [15:0] beat [0:7];
        logic [1:0]  en_or;
        int nb, last, fdc;
        nb = 0; last = -1; fdc = -1; en_or = 2'b00;
        for (int k = 0; k < 8; k++) beat[k] = 16'h0;
        hdr_en = h;
        fs = 1'b1;
        for (int i = 0; i < 30 && fdc < 0; i++) begin
            @(negedge clk);
            if (txen != 2'b00) begin
                if (nb < 8) beat[nb] = txd;
                nb++;
                last = i;
                en_or = en_or | txen;
                if (mutate && nb == 1) rxd = 32'h5555_6666;
            end
            if (fd) fdc = i;
        end
        chk({tag, "_nbeats"}, nb, exp_nb);
        chk({tag, "_beat0"}, {16'h0, beat[0]}, {16'h0, e0});
        chk({tag, "_beat1"}, {16'h0, beat[1]}, {16'h0, e1});
        if (exp_nb == 3) chk({tag, "_beat2"}, {16'h0, beat[2]}, {16'h0, e2});
        chk({tag, "_txen"}, {30'h0, en_or}, 32'h3);
        chk({tag, "_fd_latency"}, fdc, last + 1);
        fs = 1'b0;
        @(negedge clk);
        chk({tag, "_fd_release"}, {31'h0, fd}, 32'h0);
        $display("frame %s: beats=%0d fd_cycle=%0d frame_cnt=%0d", tag, nb, fdc, fcnt);
    endtask

    // Runs one frame on the 4-chip instance; returns beat count and the
    // number of beats that differ from the expected pattern.
    task automatic run2(output int nb, output int bad);
        int fdc;
        nb = 0; bad = 0; fdc = -1;
        fs2 = 1'b1;
        for (int i = 0; i < 30 && fdc < 0; i++) begin
            @(negedge clk);
            if (txen2 != 2'b00) begin
                nb++;
                if (txd2 !== 32'hAABB_CCDD) bad++;
            end
            if (fd2) fdc = i;
        end
        if (fdc < 0) bad++;
        fs2 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int nb, bad, seen;
        logic [1:0] en_or;
        logic       fd_or;

        rst_n = 1'b0; fs = 1'b0; hdr_en = 1'b0; full = 2'b00;
        rxd = 32'hABCD_1234;
        fs2 = 1'b0; hdr2 = 1'b0; full2 = 2'b00;
        rxd2 = 96'hDDDDDD_CCCCCC_BBBBBB_AAAAAA;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_fd", {31'h0, fd}, 32'h0);
        chk("rst_txen", {30'h0, txen}, 32'h0);
        chk("rst_txd", {16'h0, txd}, 32'h0);
        chk("rst_frame_cnt", {24'h0, fcnt}, 32'h0);
        chk("rst_drop_cnt", {24'h0, dcnt}, 32'h0);
        $display("reset: fd=%b txen=%b txd=%h", fd, txen, txd);
        rst_n = 1'b1;

        // 1: plain frame
        run1("t1", 1'b0, 1'b0, 16'h12AB, 16'h34CD, 16'h0, 2);
        chk("t1_frame_cnt", {24'h0, fcnt}, 32'd1);

        // 4: chip_rxd changes right after capture
        run1("t4", 1'b0, 1'b1, 16'h12AB, 16'h34CD, 16'h0, 2);
        chk("t4_frame_cnt", {24'h0, fcnt}, 32'd2);
        rxd = 32'hABCD_1234;

        // 3: full and fs together in WAIT -> drop
        full = 2'b01;
        fs = 1'b1;
        en_or = 2'b00; fd_or = 1'b0;
        repeat (4) begin
            @(negedge clk);
            en_or = en_or | txen;
            fd_or = fd_or | fd;
        end
        chk("t3_drop_txen", {30'h0, en_or}, 32'h0);
        chk("t3_drop_fd", {31'h0, fd_or}, 32'h0);
        chk("t3_drop_cnt", {24'h0, dcnt}, 32'd1);
        chk("t3_drop_frame_cnt", {24'h0, fcnt}, 32'd2);
        $display("drop: drop_cnt=%0d frame_cnt=%0d", dcnt, fcnt);
        fs = 1'b0; full = 2'b00;
        @(negedge clk);
        run1("t3_next", 1'b0, 1'b0, 16'h12AB, 16'h34CD, 16'h0, 2);
        chk("t3_frame_cnt", {24'h0, fcnt}, 32'd3);

        // advance to frame_cnt = 5
        run1("pad4", 1'b0, 1'b0, 16'h12AB, 16'h34CD, 16'h0, 2);
        run1("pad5", 1'b0, 1'b0, 16'h12AB, 16'h34CD, 16'h0, 2);
        chk("pad_frame_cnt", {24'h0, fcnt}, 32'd5);

        // 2: header frame
        run1("t2", 1'b1, 1'b0, 16'hA505, 16'h12AB, 16'h34CD, 3);
        chk("t2_frame_cnt", {24'h0, fcnt}, 32'd6);
        chk("t2_drop_cnt", {24'h0, dcnt}, 32'd1);
        hdr_en = 1'b0;

        // 5: 4 chips x 3 bytes
        run2(nb, bad);
        chk("t5_nbeats", nb, 32'd3);
        chk("t5_bad_beats", bad, 32'd0);
        chk("t5_frame_cnt_1", {24'h0, fcnt2}, 32'd1);
        $display("frame t5: beats=%0d bad=%0d frame_cnt=%0d", nb, bad, fcnt2);
        for (int f = 0; f < 254; f++) run2(nb, bad);
        chk("t5_frame_cnt_255", {24'h0, fcnt2}, 32'd255);
        run2(nb, bad);
        chk("t5_last_bad", bad, 32'd0);
        chk("t5_frame_cnt_wrap", {24'h0, fcnt2}, 32'd0);
        $display("wrap: frame_cnt=%0d after 256 frames", fcnt2);

        // 6: reset during the second beat
        fs = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            @(negedge clk);
            if (txen != 2'b00) seen = 1;
        end
        chk("t6_first_beat_seen", seen, 32'd1);
        @(negedge clk);
        chk("t6_second_beat", {16'h0, txd}, 32'h34CD);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_txen", {30'h0, txen}, 32'h0);
        chk("t6_rst_fd", {31'h0, fd}, 32'h0);
        chk("t6_rst_txd", {16'h0, txd}, 32'h0);
        chk("t6_rst_frame_cnt", {24'h0, fcnt}, 32'h0);
        chk("t6_rst_drop_cnt", {24'h0, dcnt}, 32'h0);
        $display("mid-burst reset: txen=%b fd=%b", txen, fd);
        @(negedge clk);
        rst_n = 1'b1;
        run1("t6_after", 1'b0, 1'b0, 16'h12AB, 16'h34CD, 16'h0, 2);
        chk("t6_frame_cnt", {24'h0, fcnt}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
